// File: rtl/uart_tx_arbiter_if.sv
// ----------------------------------------------------------------------------
// uart_tx_arbiter_if
// Groups the requester handshake and the UART transmit FIFO write port of
// uart_tx_arbiter.
//   req       requester -> arbiter  per-requester message request
//   req_data  requester -> arbiter  message of requester i in slice
//                                   [i*NBYTE*DBIT +: NBYTE*DBIT]
//   ack       arbiter -> requester  one-cycle pulse: message i latched
//   tx_full   UART -> arbiter       transmit FIFO full
//   wr_uart   arbiter -> UART       FIFO write strobe
//   w_data    arbiter -> UART       byte presented with wr_uart
//   busy      arbiter status        high whenever a message is in flight
//   grant_id  arbiter status        requester being sent, 0 when idle
// master: the side driving requests and FIFO status; slave: the arbiter.
// ----------------------------------------------------------------------------
interface uart_tx_arbiter_if #(
    parameter int NREQ  = 4,
    parameter int DBIT  = 8,
    parameter int NBYTE = 4
);
    logic [NREQ-1:0]            req;
    logic [NREQ*NBYTE*DBIT-1:0] req_data;
    logic [NREQ-1:0]            ack;
    logic                       tx_full;
    logic                       wr_uart;
    logic [DBIT-1:0]            w_data;
    logic                       busy;
    logic [3:0]                 grant_id;

    modport master (
        output req, req_data, tx_full,
        input  ack, wr_uart, w_data, busy, grant_id
    );

    modport slave (
        input  req, req_data, tx_full,
        output ack, wr_uart, w_data, busy, grant_id
    );
endinterface

// File: rtl/uart_tx_arbiter.sv
// ----------------------------------------------------------------------------
// uart_tx_arbiter
// Round-robin arbiter that lets NREQ requesters share one UART transmit FIFO.
// A granted requester's NBYTE*DBIT message is latched into a holding register
// and streamed LSB byte first into the FIFO, stalling while the FIFO is full.
//
// Ports:
//   clk    system clock, all state changes on its rising edge
//   reset  asynchronous, active-low reset
//   bus    uart_tx_arbiter_if.slave (req/req_data/ack, tx_full/wr_uart/
//          w_data, busy, grant_id)
//
// Parameters: NREQ (2..16), DBIT (UART data width), NBYTE (bytes/message).
//
// Optional feature: define UART_ARB_HDR_EN to prefix every message with one
// header byte {4'hA, grant_id}; without it only payload bytes are sent.
// ----------------------------------------------------------------------------
module uart_tx_arbiter #(
    parameter int NREQ  = 4,
    parameter int DBIT  = 8,
    parameter int NBYTE = 4
) (
    input  logic              clk,
    input  logic              reset,
    uart_tx_arbiter_if.slave  bus
);
    localparam int MSGW = NBYTE * DBIT;
    localparam int CW   = (NBYTE > 1) ? $clog2(NBYTE) : 1;
    localparam logic [CW-1:0] LAST_BYTE = CW'(NBYTE - 1);

`ifdef UART_ARB_HDR_EN
    typedef enum logic [1:0] {IDLE = 2'd0, HDR = 2'd1, SEND = 2'd2} state_t;
`else
    typedef enum logic [1:0] {IDLE = 2'd0, SEND = 2'd2} state_t;
`endif

    state_t            r_state;
    state_t            w_next;
    logic [MSGW-1:0]   r_hold;
    logic [CW-1:0]     r_cnt;
    logic [3:0]        r_last_grant;
    logic [3:0]        r_grant_id;
    logic [NREQ-1:0]   r_ack;

    logic [15:0]       w_req16;
    logic [4:0]        w_idx;
    logic              w_found;
    logic [3:0]        w_winner;
    logic [NREQ-1:0]   w_ack_next;
    logic              w_wr;
    logic [DBIT-1:0]   w_byte;

    assign w_req16 = 16'(bus.req);

    // Round-robin pick: first requester found scanning upward from
    // last_grant+1, wrapping at NREQ-1 back to 0.
    // NOTE: every combinational output gets a default before any branch so no
    // path leaves it unassigned, which would otherwise infer a latch.
    always_comb begin
        w_found  = 1'b0;
        w_winner = '0;
        w_idx    = '0;
        for (int i = 1; i <= NREQ; i++) begin
            w_idx = 5'(r_last_grant) + 5'(i);
            if (w_idx >= 5'(NREQ)) begin
                w_idx = w_idx - 5'(NREQ);
            end
            if (!w_found && w_req16[w_idx[3:0]]) begin
                w_found  = 1'b1;
                w_winner = w_idx[3:0];
            end
        end
    end

    always_comb begin
        w_ack_next = '0;
        for (int j = 0; j < NREQ; j++) begin
            w_ack_next[j] = (w_winner == 4'(j));
        end
    end

    // Next state and the FIFO write port. wr_uart is combinational so a full
    // FIFO blocks the write in the same cycle it is seen.
    always_comb begin
        w_next = r_state;
        w_wr   = 1'b0;
        w_byte = '0;
        case (r_state)
            IDLE: begin
                if (w_found) begin
`ifdef UART_ARB_HDR_EN
                    w_next = HDR;
`else
                    w_next = SEND;
`endif
                end
            end
`ifdef UART_ARB_HDR_EN
            HDR: begin
                w_wr   = !bus.tx_full;
                w_byte = DBIT'({4'hA, r_grant_id});
                if (w_wr) begin
                    w_next = SEND;
                end
            end
`endif
            SEND: begin
                w_wr   = !bus.tx_full;
                w_byte = r_hold[r_cnt*DBIT +: DBIT];
                if (w_wr && (r_cnt == LAST_BYTE)) begin
                    w_next = IDLE;
                end
            end
            default: w_next = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Grant capture and byte counter. The message is copied at the grant edge
    // so later req/req_data changes cannot disturb the message in flight.
    // NOTE: the holding register is reset explicitly so w_data and the held
    // message read as zero right after reset rather than stale content.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_hold       <= '0;
            r_cnt        <= '0;
            r_last_grant <= 4'(NREQ - 1);
            r_grant_id   <= '0;
            r_ack        <= '0;
        end else begin
            r_ack <= '0;
            if ((r_state == IDLE) && w_found) begin
                r_hold       <= bus.req_data[w_winner*MSGW +: MSGW];
                r_last_grant <= w_winner;
                r_grant_id   <= w_winner;
                r_cnt        <= '0;
                r_ack        <= w_ack_next;
            end else if ((r_state == SEND) && w_wr) begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign bus.ack      = r_ack;
    assign bus.wr_uart  = w_wr;
    assign bus.w_data   = w_byte;
    assign bus.busy     = (r_state != IDLE);
    assign bus.grant_id = (r_state == IDLE) ? 4'd0 : r_grant_id;

endmodule
